// File: rtl/tff_counter.sv
// tff_counter
//   Up/down counter built from a bank of WIDTH toggle flip-flops. Every state
//   change, including load, wrap and reset-free saturation, is a per-bit
//   toggle vector applied to the register, so q and qb always move together.
//   Count range is 0..MODULUS-1.
//
// Parameters
//   WIDTH    counter width in bits, 1..32
//   MODULUS  number of states, 2..2**WIDTH
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   en    in   count enable
//   up    in   1 = increment, 0 = decrement
//   load  in   synchronous parallel load (beats en)
//   d     in   load value, clamped to MODULUS-1
//   q     out  registered count
//   qb    out  registered complement of q
//   tc    out  terminal count, combinational, for cascading into next en
//   wrap  out  one-cycle registered pulse after a boundary wrap
//
// Build option
//   TFF_COUNTER_SAT_EN  when defined, the counter saturates at the range
//                       boundaries instead of wrapping; wrap stays 0.

module tff_counter #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  localparam logic [63:0]      MOD64 = 64'(MODULUS);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("tff_counter: WIDTH must be in 1..32");
  end

  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("tff_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qb_r;
  logic             wrap_r;

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] load_val;
  logic             wrap_nxt;
  logic             at_max;
  logic             at_zero;
  logic [63:0]      d_ext;

  assign at_max  = (q_r == MAX);
  assign at_zero = (q_r == '0);

  assign d_ext    = {{(64 - WIDTH){1'b0}}, d};
  assign load_val = (d_ext >= MOD64) ? MAX : d;

  // Ripple-free binary toggle vectors: bit i flips when all lower bits are
  // 1 (counting up) or all lower bits are 0, i.e. qb bits are 1 (down).
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q_r[i-1];
      t_dn[i] = t_dn[i-1] & qb_r[i-1];
    end
  end

  // Everything is expressed as a toggle: load toggles the bits that differ
  // from the target, the up-wrap toggles every set bit to reach zero, and the
  // down-wrap from zero toggles exactly the bits of MAX.
  always_comb begin
    t        = '0;
    wrap_nxt = 1'b0;
    if (load) begin
      t = q_r ^ load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
`ifdef TFF_COUNTER_SAT_EN
          t = '0;
`else
          t        = q_r;
          wrap_nxt = 1'b1;
`endif
        end else begin
          t = t_up;
        end
      end else begin
        if (at_zero) begin
`ifdef TFF_COUNTER_SAT_EN
          t = '0;
`else
          t        = MAX;
          wrap_nxt = 1'b1;
`endif
        end else begin
          t = t_dn;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= '0;
      qb_r   <= '1;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_r ^ t;
      qb_r   <= qb_r ^ t;
      wrap_r <= wrap_nxt;
    end
  end

  assign q    = q_r;
  assign qb   = qb_r;
  assign wrap = wrap_r;
  assign tc   = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_tff_counter.sv
module tb_tff_counter;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] qb;
  logic       tc;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  tff_counter #(.WIDTH(4), .MODULUS(M)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .qb   (qb),
    .tc   (tc),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: plain modular arithmetic on an integer count.
  int mq = 0;
  int mw = 0;
  int mtc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq = 0;
      mw = 0;
    end else if (load) begin
      mq = (int'(d) >= M) ? M - 1 : int'(d);
      mw = 0;
    end else if (en) begin
      mw = 0;
      if (up) begin
        if (mq == M - 1) begin
`ifdef TFF_COUNTER_SAT_EN
          mq = M - 1;
`else
          mq = 0;
          mw = 1;
`endif
        end else mq = mq + 1;
      end else begin
        if (mq == 0) begin
`ifdef TFF_COUNTER_SAT_EN
          mq = 0;
`else
          mq = M - 1;
          mw = 1;
`endif
        end else mq = mq - 1;
      end
    end else begin
      mw = 0;
    end
  end

  always @(negedge clk) begin
    logic [3:0] mq4;
    mq4 = 4'(mq);
    mtc = (en && ((up && mq == M - 1) || (!up && mq == 0))) ? 1 : 0;
    chk("model_q", q, mq);
    chk("model_qb", qb, {28'd0, ~mq4});
    chk("model_wrap", wrap, mw);
    chk("model_tc", tc, mtc);
  end

  task automatic drive(input logic l, input logic e, input logic u, input logic [3:0] dv);
    load = l;
    en   = e;
    up   = u;
    d    = dv;
    @(posedge clk);
    #2;
  endtask

`ifdef TFF_COUNTER_SAT_EN
  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
  int exp_wr[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_wr[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
`endif
  int en_pat[5]  = '{1, 0, 1, 1, 0};
  int en_exp[5]  = '{1, 1, 2, 3, 3};

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    en   = 1'b0;
    up   = 1'b1;
    d    = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset_q", q, 0);
    chk("reset_qb", qb, 15);
    chk("reset_wrap", wrap, 0);

    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'd0);
      chk("up_q", q, exp_up[i]);
      chk("up_wrap", wrap, exp_wr[i]);
      chk("up_tc", tc, (exp_up[i] == 9) ? 1 : 0);
    end

    drive(1'b0, 1'b1, 1'b0, 4'd0);
`ifdef TFF_COUNTER_SAT_EN
    chk("after_up_down_q", q, 8);
`else
    chk("after_up_down_q", q, 1);
`endif

    // Asynchronous reset with q=9 and no clock edge.
    drive(1'b1, 1'b0, 1'b1, 4'd9);
    chk("preload9_q", q, 9);
    load = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_q", q, 0);
    chk("async_rst_qb", qb, 15);
    chk("async_rst_wrap", wrap, 0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    chk("post_rst_q", q, 1);

    // Down from zero.
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    en = 1'b1;
    up = 1'b0;
    #1;
    chk("down_tc_at0", tc, 1);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
`ifdef TFF_COUNTER_SAT_EN
    chk("down_wrap_q", q, 0);
    chk("down_wrap_w", wrap, 0);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    chk("down_next_q", q, 0);
`else
    chk("down_wrap_q", q, 9);
    chk("down_wrap_w", wrap, 1);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    chk("down_next_q", q, 8);
`endif
    chk("down_next_w", wrap, 0);

    // Load clamp, load beats en.
    drive(1'b1, 1'b1, 1'b1, 4'd13);
    chk("clamp13_q", q, 9);
    chk("clamp13_w", wrap, 0);
    drive(1'b1, 1'b1, 1'b0, 4'd15);
    chk("clamp15_q", q, 9);
    drive(1'b1, 1'b0, 1'b0, 4'd5);
    chk("load5_q", q, 5);
    drive(1'b1, 1'b1, 1'b0, 4'd10);
    chk("clamp10_q", q, 9);

    // Direction change at the boundary: back-to-back wraps.
    drive(1'b0, 1'b1, 1'b1, 4'd0);
`ifdef TFF_COUNTER_SAT_EN
    chk("dir_up_q", q, 9);
    chk("dir_up_w", wrap, 0);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    chk("dir_dn_q", q, 8);
    chk("dir_dn_w", wrap, 0);
`else
    chk("dir_up_q", q, 0);
    chk("dir_up_w", wrap, 1);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    chk("dir_dn_q", q, 9);
    chk("dir_dn_w", wrap, 1);
`endif

    // Enable toggling from zero.
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, en_pat[i][0], 1'b1, 4'd0);
      chk("en_pat_q", q, en_exp[i]);
      chk("en_pat_qb", qb, 15 - en_exp[i]);
    end

    drive(1'b0, 1'b0, 1'b1, 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
